ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter RAM_BYTES, default 16: number of RAM bytes written per load session.
REQ-002 Parameter ADDR_W, default 4: width of the mem_addr output; RAM_BYTES SHALL be ≤ 2^ADDR_W.
REQ-003 Port clk  input  1  single clock, rising edge; the only clock in the block.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port load_req  input  1  host level request to load a program; asynchronous pin.
REQ-006 Port in_strobe  input  1  host byte strobe; asynchronous pin; each rising edge presents one byte.
REQ-007 Port in_data  input  8  host byte; stable from ≥3 clk before to ≥1 clk after the in_strobe rising edge.
REQ-008 Port cpu_hold  output  1  high holds the CPU (PC/control stalled, bus released) while loading.
REQ-009 Port mem_addr  output  ADDR_W  RAM write address.
REQ-010 Port mem_data  output  8  RAM write data.
REQ-011 Port mem_we  output  1  RAM write strobe, active-high, one clk wide.
REQ-012 Port ack  output  1  one-clk pulse per byte accepted into RAM.
REQ-013 Port done  output  1  high when all RAM_BYTES bytes have been written.
REQ-014 Port err  output  1  sticky overrun flag.

Function
REQ-015 load_req and in_strobe SHALL each pass through a 2-flop synchronizer; an edge SHALL be detected from the 2nd-stage output against a 3rd flop.
REQ-016 The FSM SHALL have the states IDLE, WAIT_BYTE, WRITE, ACK, DONE.
REQ-017 IDLE: on a synced load_req rising edge -> WAIT_BYTE, and SHALL clear the address counter to 0, err to 0, and done to 0.
REQ-018 WAIT_BYTE: on a synced in_strobe rising edge, SHALL capture in_data into the data register -> WRITE.
REQ-019 WRITE (1 clk): mem_we=1, mem_addr=counter, mem_data=captured byte, all stable this cycle -> ACK.
REQ-020 ACK (1 clk): ack=1; if counter==RAM_BYTES-1 -> DONE, else counter+1 -> WAIT_BYTE.
REQ-021 DONE: done=1; on synced load_req low -> IDLE with done held at 1 until the next session starts.
REQ-022 Latency: mem_we SHALL assert exactly 4 clk after the raw in_strobe rising edge (2 sync, 1 detect/capture, 1 WRITE).
REQ-023 cpu_hold SHALL be 1 in WAIT_BYTE, WRITE, ACK and DONE, and 0 in IDLE.
REQ-024 An in_strobe edge detected in WRITE or ACK SHALL set err; that byte SHALL be dropped and the counter unaffected.
REQ-025 A synced load_req fall in WAIT_BYTE -> IDLE (abort); done SHALL stay 0, and bytes already written SHALL remain.
REQ-026 A synced load_req fall in WRITE or ACK SHALL let the current write and ack complete, then -> IDLE.
REQ-027 A load_req rising edge while not in IDLE SHALL be ignored.
REQ-028 The counter SHALL never exceed RAM_BYTES-1; no wrap-around writes SHALL occur within a session.
REQ-029 mem_we and ack SHALL never be high outside WRITE and ACK respectively.

Reset
REQ-030 With rst=1 at a clk edge, the block SHALL enter IDLE, all synchronizer flops SHALL be 0, and outputs SHALL be cpu_hold=0, mem_we=0, ack=0, done=0, err=0, mem_addr=0, mem_data=0x00.
REQ-031 Reset mid-session SHALL abandon the session immediately, with no further mem_we.
REQ-032 After rst falls, a load_req already held high SHALL NOT start a session until it goes low and then high again.

Verification
REQ-033 Full load: load_req high, 16 strobes of bytes 0x10..0x1F spaced 8 clk -> 16 mem_we pulses at addr 0..15 with data 0x10..0x1F, done=1, err=0, cpu_hold=1 until load_req falls.
REQ-034 Latency: in_strobe rises at cycle N with in_data=0xA5 -> mem_we=1, mem_addr=0, mem_data=0xA5 at cycle N+4, and ack=1 at N+5.
REQ-035 Overrun: second strobe edge detected during ACK -> err=1, byte dropped, next valid byte written at the unchanged next address.
REQ-036 Abort: load_req falls after 5 bytes -> IDLE, cpu_hold=0, done=0; a new session restarts at addr 0.
REQ-037 Reset mid-write: rst asserted in the cycle after WRITE -> no further mem_we, all outputs at reset values next clk.
REQ-038 Re-arm: load_req held high through reset release -> no session; low then high -> session starts at addr 0.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: loads a program from an asynchronous host byte port into RAM.
// While a session is running the CPU is held off the bus. Each host strobe
// produces one RAM write followed by a one-cycle ack. A strobe that arrives
// while a write is still in flight is dropped and latches the sticky err flag.
module ram_loader #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4      // RAM_BYTES must not exceed 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_strobe,
    input  logic [7:0]        in_data,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              ack,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WRITE,
        ACK,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    state_t            state;
    state_t            state_next;
    logic [2:0]        load_sync;
    logic [2:0]        strobe_sync;
    logic [1:0]        warm_cnt;
    logic              armed;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        data_reg;
    logic              done_reg;
    logic              err_reg;

    // Bit 1 is the synchronized level; bit 2 is the delayed copy used for edges.
    logic load_level;
    logic load_start;
    logic strobe_rise;
    logic at_last;

    assign load_level  = load_sync[1];
    assign load_start  = load_sync[1] & ~load_sync[2] & armed;
    assign strobe_rise = strobe_sync[1] & ~strobe_sync[2];
    assign at_last     = (addr_cnt == LAST_ADDR);

    // Two-flop synchronizers plus a third flop for edge detection on both host pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_sync   <= 3'b000;
            strobe_sync <= 3'b000;
        end else begin
            load_sync   <= {load_sync[1:0], load_req};
            strobe_sync <= {strobe_sync[1:0], in_strobe};
        end
    end

    // Arm session starts only after load_req has been seen low following reset,
    // so a request held high across reset release cannot start a session.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (warm_cnt != 2'd3) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            if (warm_cnt == 2'd3 && !load_level) begin
                armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; an abort in WRITE/ACK is deferred until ACK finishes.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (!load_level) begin
                    state_next = IDLE;
                end else if (strobe_rise) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = ACK;
            end
            ACK: begin
                if (at_last) begin
                    state_next = DONE;
                end else if (!load_level) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_BYTE;
                end
            end
            DONE: begin
                if (!load_level) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address counter, captured byte, and the done/err status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= '0;
            data_reg <= 8'h00;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        addr_cnt <= '0;
                        done_reg <= 1'b0;
                        err_reg  <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (load_level && strobe_rise) begin
                        data_reg <= in_data;
                    end
                end
                WRITE: begin
                    if (strobe_rise) begin
                        err_reg <= 1'b1;
                    end
                end
                ACK: begin
                    if (strobe_rise) begin
                        err_reg <= 1'b1;
                    end
                    if (at_last) begin
                        done_reg <= 1'b1;
                    end else if (load_level) begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM outputs decoded from the current state and datapath registers.
    always_comb begin
        cpu_hold = (state != IDLE);
        mem_we   = (state == WRITE);
        ack      = (state == ACK);
        mem_addr = addr_cnt;
        mem_data = data_reg;
        done     = done_reg;
        err      = err_reg;
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed bench for ram_loader. Every RAM write seen on the
// bus is logged, and the directed steps below compare the log and the live
// outputs against hand-computed values.
module tb_ram_loader;

    logic       clk;
    logic       rst;
    logic       load_req;
    logic       in_strobe;
    logic [7:0] in_data;
    logic       cpu_hold;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       ack;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];

    ram_loader #(
        .RAM_BYTES(16),
        .ADDR_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .in_strobe(in_strobe),
        .in_data  (in_data),
        .cpu_hold (cpu_hold),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .ack      (ack),
        .done     (done),
        .err      (err)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every write exactly as the RAM would capture it.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_log.push_back({4'h0, mem_addr});
            wr_data_log.push_back(mem_data);
        end
    end

    // Advance n rising edges, then settle 1 unit so outputs are stable.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One host byte: data settles 3 clk ahead, strobe high 2 clk, 8 clk total.
    task automatic apply_stimulus(input logic [7:0] b);
        in_data = b;
        step(3);
        in_strobe = 1'b1;
        step(2);
        in_strobe = 1'b0;
        step(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_cpu_hold"}, cpu_hold, 0);
        check_output({tag, "_mem_we"},   mem_we,   0);
        check_output({tag, "_ack"},      ack,      0);
        check_output({tag, "_done"},     done,     0);
        check_output({tag, "_err"},      err,      0);
        check_output({tag, "_mem_addr"}, mem_addr, 0);
        check_output({tag, "_mem_data"}, mem_data, 8'h00);
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        load_req  = 1'b0;
        in_strobe = 1'b0;
        in_data   = 8'h00;
        $display("[TB] start");

        // Reset state.
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(4);
        check_output("idle_cpu_hold", cpu_hold, 0);

        // Latency: strobe raised just after edge N, the write shows during the
        // cycle ending at edge N+4 and the ack during the one ending at N+5.
        load_req = 1'b1;
        step(4);
        check_output("lat_hold", cpu_hold, 1);
        base = wr_addr_log.size();
        in_data = 8'hA5;
        step(3);
        in_strobe = 1'b1;
        step(2);
        check_output("lat_we_early", mem_we, 0);
        step(1);
        check_output("lat_we",   mem_we,   1);
        check_output("lat_addr", mem_addr, 0);
        check_output("lat_data", mem_data, 8'hA5);
        check_output("lat_ack_early", ack, 0);
        step(1);
        check_output("lat_we_after", mem_we, 0);
        check_output("lat_ack", ack, 1);
        step(1);
        check_output("lat_ack_after", ack, 0);
        in_strobe = 1'b0;
        step(3);
        check_output("lat_count", wr_addr_log.size() - base, 1);
        load_req = 1'b0;
        step(4);
        check_output("lat_abort_hold", cpu_hold, 0);
        check_output("lat_abort_done", done, 0);

        // Full 16-byte load of 0x10..0x1F.
        load_req = 1'b1;
        step(4);
        base = wr_addr_log.size();
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(8'h10 + 8'(i));
        end
        step(2);
        check_output("full_count", wr_addr_log.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("full_addr%0d", i), wr_addr_log[base + i], i);
            check_output($sformatf("full_data%0d", i), wr_data_log[base + i], 8'h10 + i);
        end
        check_output("full_done", done, 1);
        check_output("full_err",  err,  0);
        check_output("full_hold", cpu_hold, 1);
        load_req = 1'b0;
        step(4);
        check_output("full_release_hold", cpu_hold, 0);
        check_output("full_release_done", done, 1);

        // Overrun: second strobe edge lands in ACK and must be dropped.
        load_req = 1'b1;
        step(4);
        check_output("ovr_done_cleared", done, 0);
        check_output("ovr_err_clear", err, 0);
        base = wr_addr_log.size();
        apply_stimulus(8'h31);
        in_data = 8'h32;
        step(3);
        in_strobe = 1'b1;
        step(1);
        in_strobe = 1'b0;
        step(1);
        in_strobe = 1'b1;
        step(1);
        in_data = 8'hEE;
        step(2);
        check_output("ovr_err", err, 1);
        in_strobe = 1'b0;
        step(3);
        apply_stimulus(8'h33);
        step(1);
        check_output("ovr_count", wr_addr_log.size() - base, 3);
        check_output("ovr_addr2", wr_addr_log[base + 1], 1);
        check_output("ovr_data2", wr_data_log[base + 1], 8'h32);
        check_output("ovr_addr3", wr_addr_log[base + 2], 2);
        check_output("ovr_data3", wr_data_log[base + 2], 8'h33);
        check_output("ovr_err_sticky", err, 1);
        load_req = 1'b0;
        step(4);

        // Abort after 5 bytes, then restart at address 0.
        load_req = 1'b1;
        step(4);
        base = wr_addr_log.size();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(8'h40 + 8'(i));
        end
        load_req = 1'b0;
        step(4);
        check_output("abort_hold",  cpu_hold, 0);
        check_output("abort_done",  done, 0);
        check_output("abort_count", wr_addr_log.size() - base, 5);
        check_output("abort_last_addr", wr_addr_log[base + 4], 4);
        load_req = 1'b1;
        step(4);
        base = wr_addr_log.size();
        apply_stimulus(8'h50);
        check_output("restart_addr", wr_addr_log[base], 0);
        check_output("restart_data", wr_data_log[base], 8'h50);
        check_output("restart_err",  err, 0);

        // Reset asserted during the ACK that follows a WRITE.
        base = wr_addr_log.size();
        in_data = 8'h51;
        step(3);
        in_strobe = 1'b1;
        step(3);
        check_output("rstmid_we",   mem_we, 1);
        check_output("rstmid_addr", mem_addr, 1);
        step(1);
        rst = 1'b1;
        step(1);
        check_reset_outputs("rstmid");
        in_strobe = 1'b0;
        step(3);
        check_output("rstmid_count", wr_addr_log.size() - base, 1);

        // load_req stays high through reset release: no session until re-armed.
        rst = 1'b0;
        step(6);
        check_output("rearm_idle_hold", cpu_hold, 0);
        base = wr_addr_log.size();
        apply_stimulus(8'h60);
        check_output("rearm_no_write", wr_addr_log.size() - base, 0);
        check_output("rearm_still_idle", cpu_hold, 0);
        load_req = 1'b0;
        step(4);
        load_req = 1'b1;
        step(4);
        check_output("rearm_hold", cpu_hold, 1);
        apply_stimulus(8'h61);
        check_output("rearm_count", wr_addr_log.size() - base, 1);
        check_output("rearm_addr", wr_addr_log[base], 0);
        check_output("rearm_data", wr_data_log[base], 8'h61);
        load_req = 1'b0;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
